cmsdk_apb3_eg_slave_reg_arb: RTL and testbench

Two-port arbiter and access sequencer for the example-slave register block. Two independent requesters (port 0: APB3 bus front-end, port 1: local debug/DMA agent) share that block's single register interface (addr, read_en, write_en, wdata, rdata). The block grants one requester at a time with round-robin priority and inserts a programmable number of wait states. It issues exactly one single-cycle read or write strobe per transaction and returns read data with a completion pulse.

---
 rtl/cmsdk_apb3_eg_slave_arb_pkg.sv | 14 +
 rtl/cmsdk_apb3_eg_slave_reg_arb_if.sv | 42 ++++
 rtl/cmsdk_apb3_eg_slave_reg_arb_rr_pick.sv | 19 +
 rtl/cmsdk_apb3_eg_slave_reg_arb.sv | 126 ++++++++++++
 tb/tb_cmsdk_apb3_eg_slave_reg_arb.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cmsdk_apb3_eg_slave_arb_pkg.sv
// Shared constants for the example-slave register arbiter: FSM encoding,
// wait counter width and requester count.
package cmsdk_apb3_eg_slave_arb_pkg;

  localparam int WAIT_W    = 4;
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cmsdk_apb3_eg_slave_reg_arb_if.sv
// Request/ack bundle for both requesters plus the shared register-block port.
// The slave modport is the arbiter view; master is the requester/regblock side.
interface cmsdk_apb3_eg_slave_reg_arb_if #(
  parameter int ADDRWIDTH = 12
);
  logic                 req0_valid;
  logic                 req0_write;
  logic [ADDRWIDTH-1:0] req0_addr;
  logic [31:0]          req0_wdata;
  logic                 ack0;
  logic [31:0]          rdata0;

  logic                 req1_valid;
  logic                 req1_write;
  logic [ADDRWIDTH-1:0] req1_addr;
  logic [31:0]          req1_wdata;
  logic                 ack1;
  logic [31:0]          rdata1;

  logic [ADDRWIDTH-1:0] reg_addr;
  logic                 reg_read_en;
  logic                 reg_write_en;
  logic [31:0]          reg_wdata;
  logic [31:0]          reg_rdata;
  logic                 busy;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  reg_rdata,
    output ack0, rdata0, ack1, rdata1,
    output reg_addr, reg_read_en, reg_write_en, reg_wdata, busy
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output reg_rdata,
    input  ack0, rdata0, ack1, rdata1,
    input  reg_addr, reg_read_en, reg_write_en, reg_wdata, busy
  );
endinterface

// File: rtl/cmsdk_apb3_eg_slave_reg_arb_rr_pick.sv
// Combinational two-way round-robin picker: on contention the port that
// did not win last time is granted.
module cmsdk_apb3_eg_slave_rr_pick
  import cmsdk_apb3_eg_slave_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] valid,
  input  logic                 last,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 any
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

  assign any = |valid;

endmodule

// File: rtl/cmsdk_apb3_eg_slave_reg_arb.sv
// Arbitrates two requesters onto the example-slave register port, inserting
// WAIT_CYCLES wait states and issuing one registered strobe per transaction.
module cmsdk_apb3_eg_slave_reg_arb
  import cmsdk_apb3_eg_slave_arb_pkg::*;
#(
  parameter int ADDRWIDTH   = 12,
  parameter int WAIT_CYCLES = 0
) (
  input logic                           pclk,
  input logic                           preset,
  cmsdk_apb3_eg_slave_reg_arb_if.slave  bus
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);
  localparam logic              NO_WAIT   = (WAIT_CYCLES == 0);

  arb_state_t           state;
  logic [WAIT_W-1:0]    wait_cnt;
  logic                 dir;
  logic                 gnt_port;
  logic                 last_q;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata0_q;
  logic [31:0]          rdata1_q;
  logic                 ack0_q;
  logic                 ack1_q;
  logic                 rd_en_q;
  logic                 wr_en_q;
  logic                 busy_q;

  logic [1:0]           grant;
  logic                 any;
  logic                 sel_write;
  logic [ADDRWIDTH-1:0] sel_addr;
  logic [31:0]          sel_wdata;

  cmsdk_apb3_eg_slave_rr_pick u_pick (
    .valid ({bus.req1_valid, bus.req0_valid}),
    .last  (last_q),
    .grant (grant),
    .any   (any)
  );

  assign sel_write = grant[1] ? bus.req1_write : bus.req0_write;
  assign sel_addr  = grant[1] ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = grant[1] ? bus.req1_wdata : bus.req0_wdata;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      dir      <= 1'b0;
      gnt_port <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            gnt_port <= grant[1];
            last_q   <= grant[1];
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            dir      <= sel_write;
            wait_cnt <= WAIT_INIT;
            // With no wait states the strobe must already be up in the first ACCESS cycle.
            rd_en_q  <= NO_WAIT && !sel_write;
            wr_en_q  <= NO_WAIT && sel_write;
            busy_q   <= 1'b1;
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
            if (wait_cnt == WAIT_W'(1)) begin
              rd_en_q <= !dir;
              wr_en_q <= dir;
            end
          end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            if (!dir) begin
              if (gnt_port) rdata1_q <= bus.reg_rdata;
              else          rdata0_q <= bus.reg_rdata;
            end
            ack0_q <= !gnt_port;
            ack1_q <= gnt_port;
            state  <= ST_COMPLETE;
          end
        end
        ST_COMPLETE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack0         = ack0_q;
  assign bus.ack1         = ack1_q;
  assign bus.rdata0       = rdata0_q;
  assign bus.rdata1       = rdata1_q;
  assign bus.reg_addr     = addr_q;
  assign bus.reg_wdata    = wdata_q;
  assign bus.reg_read_en  = rd_en_q;
  assign bus.reg_write_en = wr_en_q;
  assign bus.busy         = busy_q;

  // The granted requester must keep its request up until it sees its ack.
  a_req_held: assert property (@(posedge pclk) disable iff (preset)
    (state == ST_ACCESS) |-> (gnt_port ? bus.req1_valid : bus.req0_valid));

endmodule

// File: tb/tb_cmsdk_apb3_eg_slave_reg_arb.sv
// Directed bench: three arbiters (0, 3 and 5 wait states) sharing one
// register-block model that holds data0..data3 and the peripheral ID words.
module tb_cmsdk_apb3_eg_slave_reg_arb;

  logic        pclk;
  logic [2:0]  rst;
  logic        preload;
  logic [3:0][31:0] mem;

  logic        v   [3][2];
  logic        w   [3][2];
  logic [11:0] a   [3][2];
  logic [31:0] wd  [3][2];
  logic        ack_o [3][2];
  logic [31:0] rd_o  [3][2];
  logic        re_o [3];
  logic        we_o [3];
  logic        busy_o [3];
  logic [11:0] ra_o [3];
  logic [31:0] rwd_o [3];

  int n_cmp = 0;
  int n_err = 0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic logic [31:0] reg_model(input logic [11:0] ad, input logic [3:0][31:0] m);
    logic [31:0] r;
    r = 32'h0;
    if (ad[11:4] == 8'h00) r = m[ad[3:2]];
    else begin
      case (ad[11:2])
        10'h3F4: r = 32'h04;
        10'h3F8: r = 32'h18;
        10'h3F9: r = 32'hB8;
        10'h3FA: r = 32'h1B;
        10'h3FC: r = 32'h0D;
        10'h3FD: r = 32'hF0;
        10'h3FE: r = 32'h05;
        10'h3FF: r = 32'hB1;
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  always @(posedge pclk) begin
    if (preload) begin
      mem    <= '0;
      mem[1] <= 32'hA5A5_0001;
    end
    for (int g = 0; g < 3; g++)
      if (we_o[g] && ra_o[g][11:4] == 8'h00) mem[ra_o[g][3:2]] <= rwd_o[g];
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WC = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
    cmsdk_apb3_eg_slave_reg_arb_if #(.ADDRWIDTH(12)) bus ();

    assign bus.req0_valid = v[g][0];
    assign bus.req0_write = w[g][0];
    assign bus.req0_addr  = a[g][0];
    assign bus.req0_wdata = wd[g][0];
    assign bus.req1_valid = v[g][1];
    assign bus.req1_write = w[g][1];
    assign bus.req1_addr  = a[g][1];
    assign bus.req1_wdata = wd[g][1];
    assign bus.reg_rdata  = reg_model(bus.reg_addr, mem);

    assign ack_o[g][0] = bus.ack0;
    assign ack_o[g][1] = bus.ack1;
    assign rd_o[g][0]  = bus.rdata0;
    assign rd_o[g][1]  = bus.rdata1;
    assign re_o[g]     = bus.reg_read_en;
    assign we_o[g]     = bus.reg_write_en;
    assign busy_o[g]   = bus.busy;
    assign ra_o[g]     = bus.reg_addr;
    assign rwd_o[g]    = bus.reg_wdata;

    cmsdk_apb3_eg_slave_reg_arb #(.ADDRWIDTH(12), .WAIT_CYCLES(WC)) u_dut (
      .pclk   (pclk),
      .preset (rst[g]),
      .bus    (bus)
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input int i);
    chk("rst_ack0",   32'(ack_o[i][0]), 32'd0);
    chk("rst_ack1",   32'(ack_o[i][1]), 32'd0);
    chk("rst_rdata0", rd_o[i][0], 32'd0);
    chk("rst_rdata1", rd_o[i][1], 32'd0);
    chk("rst_addr",   32'(ra_o[i]), 32'd0);
    chk("rst_wdata",  rwd_o[i], 32'd0);
    chk("rst_rd_en",  32'(re_o[i]), 32'd0);
    chk("rst_wr_en",  32'(we_o[i]), 32'd0);
    chk("rst_busy",   32'(busy_o[i]), 32'd0);
  endtask

  // Cycle k counts from the IDLE cycle in which the request is sampled (k=0).
  task automatic do_txn(input int i, input int p, input logic wr, input logic [11:0] ad,
                        input logic [31:0] dat, output int stb_cyc, output int n_stb,
                        output int ack_cyc, output logic [11:0] stb_addr);
    stb_cyc = -1; n_stb = 0; ack_cyc = -1; stb_addr = '0;
    v[i][p] = 1'b1; w[i][p] = wr; a[i][p] = ad; wd[i][p] = dat;
    for (int k = 1; k <= 40 && ack_cyc < 0; k++) begin
      @(negedge pclk);
      if (re_o[i] || we_o[i]) begin
        n_stb++;
        if (stb_cyc < 0) begin stb_cyc = k; stb_addr = ra_o[i]; end
      end
      if (ack_o[i][p]) begin ack_cyc = k; v[i][p] = 1'b0; end
    end
    v[i][p] = 1'b0;
    @(negedge pclk);
  endtask

  int ack_port [8];
  int ack_at   [8];
  int nack;
  int wstb;

  // Both ports request; an acked port re-requests in the following IDLE cycle until n are issued.
  task automatic run_both(input int i, input int n);
    int k;
    int issued;
    logic rearm [2];
    nack = 0; wstb = 0; k = 0; issued = 2;
    rearm[0] = 1'b0; rearm[1] = 1'b0;
    v[i][0] = 1'b1; v[i][1] = 1'b1;
    while (nack < n && k < 200) begin
      @(negedge pclk);
      k++;
      for (int p = 0; p < 2; p++)
        if (rearm[p]) begin v[i][p] = 1'b1; rearm[p] = 1'b0; end
      if (we_o[i]) wstb++;
      for (int p = 0; p < 2; p++) begin
        if (ack_o[i][p] && nack < 8) begin
          ack_port[nack] = p; ack_at[nack] = k; nack++;
          v[i][p] = 1'b0;
          if (issued < n) begin rearm[p] = 1'b1; issued++; end
        end
      end
    end
    chk("both_ack_count", 32'(nack), 32'(n));
    v[i][0] = 1'b0; v[i][1] = 1'b0;
    @(negedge pclk);
  endtask

  task automatic rst_pulse(input int i);
    rst[i] = 1'b1;
    @(negedge pclk);
    rst[i] = 1'b0;
  endtask

  initial begin
    int sc, ns, ac, quiet;
    logic [11:0] sa;
    rst = 3'b111; preload = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int p = 0; p < 2; p++) begin
        v[i][p] = 1'b0; w[i][p] = 1'b0; a[i][p] = '0; wd[i][p] = '0;
      end
    repeat (3) @(negedge pclk);
    chk_reset(0);
    rst = 3'b000; preload = 1'b1;
    @(negedge pclk);
    preload = 1'b0;

    // Zero-wait read of data1 from port 0
    do_txn(0, 0, 1'b0, 12'h004, 32'h0, sc, ns, ac, sa);
    chk("rd0_strobe_cyc", 32'(sc), 32'd1);
    chk("rd0_strobe_cnt", 32'(ns), 32'd1);
    chk("rd0_strobe_addr", 32'(sa), 32'h004);
    chk("rd0_ack_cyc", 32'(ac), 32'd2);
    chk("rd0_rdata0", rd_o[0][0], 32'hA5A5_0001);
    chk("rd0_busy_after", 32'(busy_o[0]), 32'd0);

    // Simultaneous writes after reset: port 0 must win the first contention
    rst_pulse(0);
    w[0][0] = 1'b1; a[0][0] = 12'h000; wd[0][0] = 32'h1111_1111;
    w[0][1] = 1'b1; a[0][1] = 12'h008; wd[0][1] = 32'h2222_2222;
    run_both(0, 2);
    chk("cont_first_port", 32'(ack_port[0]), 32'd0);
    chk("cont_second_port", 32'(ack_port[1]), 32'd1);
    chk("cont_first_ack", 32'(ack_at[0]), 32'd2);
    chk("cont_second_ack", 32'(ack_at[1]), 32'd5);
    chk("cont_wr_strobes", 32'(wstb), 32'd2);
    chk("cont_data0", mem[0], 32'h1111_1111);
    chk("cont_data2", mem[2], 32'h2222_2222);

    // Continuous contention: six reads of data0 alternating 0,1,...
    w[0][0] = 1'b0; a[0][0] = 12'h000;
    w[0][1] = 1'b0; a[0][1] = 12'h000;
    run_both(0, 6);
    for (int j = 0; j < 6; j++) chk($sformatf("rr_port_%0d", j), 32'(ack_port[j]), 32'(j % 2));
    for (int j = 1; j < 6; j++) chk($sformatf("rr_gap_%0d", j), 32'(ack_at[j] - ack_at[j-1]), 32'd3);
    chk("rr_rdata0", rd_o[0][0], 32'h1111_1111);
    chk("rr_rdata1", rd_o[0][1], 32'h1111_1111);

    // Read after write; port 1 read data survives port 0 writes
    do_txn(0, 0, 1'b1, 12'h00C, 32'hDEAD_BEEF, sc, ns, ac, sa);
    chk("raw_wr_ack", 32'(ac), 32'd2);
    chk("raw_wr_strobes", 32'(ns), 32'd1);
    do_txn(0, 1, 1'b0, 12'h00C, 32'h0, sc, ns, ac, sa);
    chk("raw_rdata1", rd_o[0][1], 32'hDEAD_BEEF);
    do_txn(0, 0, 1'b1, 12'h000, 32'h1234_5678, sc, ns, ac, sa);
    chk("raw_rdata1_kept", rd_o[0][1], 32'hDEAD_BEEF);
    chk("raw_wr_keeps_rdata0", rd_o[0][0], 32'h1111_1111);
    do_txn(0, 0, 1'b0, 12'h00C, 32'h0, sc, ns, ac, sa);
    chk("raw_rdata0", rd_o[0][0], 32'hDEAD_BEEF);

    // Three wait states: port 0 then port 1 reading PID0
    do_txn(1, 0, 1'b0, 12'h004, 32'h0, sc, ns, ac, sa);
    chk("w3_rd0_ack", 32'(ac), 32'd5);
    do_txn(1, 1, 1'b0, 12'hFE0, 32'h0, sc, ns, ac, sa);
    chk("w3_strobe_cyc", 32'(sc), 32'd4);
    chk("w3_strobe_cnt", 32'(ns), 32'd1);
    chk("w3_ack_cyc", 32'(ac), 32'd5);
    chk("w3_rdata1", rd_o[1][1], 32'h0000_0018);
    chk("w3_rdata0_kept", rd_o[1][0], 32'hA5A5_0001);

    // Five wait states: reset in the middle of ACCESS aborts the transaction
    do_txn(2, 0, 1'b0, 12'h008, 32'h0, sc, ns, ac, sa);
    chk("w5_pre_ack", 32'(ac), 32'd7);
    chk("w5_pre_rdata0", rd_o[2][0], 32'h2222_2222);
    v[2][0] = 1'b1; w[2][0] = 1'b0; a[2][0] = 12'h004;
    repeat (2) @(negedge pclk);
    chk("w5_busy_in_access", 32'(busy_o[2]), 32'd1);
    rst[2] = 1'b1;
    @(negedge pclk);
    chk_reset(2);
    v[2][0] = 1'b0; rst[2] = 1'b0;
    quiet = 0;
    repeat (12) begin
      @(negedge pclk);
      if (re_o[2] || we_o[2] || ack_o[2][0] || ack_o[2][1]) quiet++;
    end
    chk("w5_abort_quiet", 32'(quiet), 32'd0);
    do_txn(2, 0, 1'b0, 12'h004, 32'h0, sc, ns, ac, sa);
    chk("w5_post_strobe", 32'(sc), 32'd6);
    chk("w5_post_ack", 32'(ac), 32'd7);
    chk("w5_post_rdata0", rd_o[2][0], 32'hA5A5_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
